mem_wb_elastic_reg: RTL
=======================

# mem_wb_elastic_reg

Parametrised MEM→WB pipeline register with valid/ready flow control, a one-entry skid buffer, flush, write-back result selection and a forwarding lookup port. Sits between the memory stage and register-file write-back. Replaces the fixed 32-bit load-enable register, so that a multi-cycle memory stage or a stalled write-back port can apply back-pressure without losing an instruction. It also lets the hazard unit forward from both buffered entries.

## Interface
Parameters:
- DATA_W, 32, width of ALU result, memory read value and forwarded value
- REG_W, 4, width of destination and source register indices

Ports:
- clk  in  1  rising-edge clock; sole clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held entries; any input offered this cycle is not accepted
- in_valid  in  1  MEM stage offers an instruction
- in_ready  out  1  block can accept; registered
- WB_en_in, Mem_R_en_in  in  1 each  control bits of offered instruction
- ALU_result_in, Mem_read_value_in  in  DATA_W each  offered data
- Dest_in  in  REG_W  offered destination register
- out_valid  out  1  head entry present
- out_ready  in  1  write-back consumes head
- WB_en, Mem_R_en  out  1 each  head control; both forced 0 when out_valid=0
- ALU_result, Mem_read_value  out  DATA_W each  head data
- Dest  out  REG_W  head destination
- wb_value  out  DATA_W  head value to write: Mem_read_value if Mem_R_en else ALU_result
- src_a, src_b  in  REG_W each  hazard-unit query registers
- fwd_a_hit, fwd_b_hit  out  1 each  a held entry writes that register
- fwd_a_value, fwd_b_value  out  DATA_W each  write-back value of matching entry; 0 when no hit
- occupancy  out  2  entries held: 0, 1 or 2

## Operation
- Storage: head entry H and skid entry S. Each has a valid bit, WB_en, Mem_R_en, ALU_result, Mem_read_value and Dest.
- accept = in_valid & in_ready & ~flush. pop = out_valid & out_ready.
- Next state, evaluated with flush first:
  - flush: H.valid and S.valid cleared; payload contents don't matter.
  - empty + accept: input → H.
  - H only, pop, accept: input → H.
  - H only, pop, no accept: H cleared.
  - H only, no pop, accept: input → S.
  - H+S, pop: S → H, S cleared. in_ready was 0, so there is no accept.
  - H+S, no pop: hold.
- in_ready = ~S.valid as registered state.
- out_valid = H.valid. Head payload is stable while out_valid & ~out_ready.
- Ordering: S is always younger than H. Output order equals accept order; no drop or duplicate.
- Forwarding: an entry matches src when valid & WB_en & Dest==src. S match takes priority over H. Index 0 gets no special case; R0 is forwarded like any register.
- occupancy = H.valid + S.valid.
- Reset: H.valid=S.valid=0. All data and Dest fields = 0. in_ready=1 from the first cycle after rst deasserts. Every output reads 0 except in_ready.
- Inputs are ignored while rst=1; reset beats flush and accept. Reset mid-stall discards both entries.

## Timing
- Latency: accept at edge N → out_valid, payload valid after edge N, i.e. usable in cycle N+1.
- Throughput: 1 instruction/cycle with out_ready held high; S stays empty.
- Back-pressure: first stalled accept lands in S. in_ready falls after that edge, one cycle after the stall. Minimum skid depth 1 is therefore sufficient.
- in_ready rises the cycle after the pop that drains S.
- Flush: takes effect at the edge it is sampled. out_valid=0 and in_ready=1 in the following cycle.
- Forwarding outputs, wb_value and the gated WB_en/Mem_R_en are combinational from registered state and query inputs. They add no cycle.

## Structure
- Shared package/include `mem_wb_pkg`:
  - entry field width localparams
  - entry payload struct (or packed-vector offsets)
  - function `wb_select(mem_r_en, alu, mem)`
- Sub-module `mem_wb_fwd_match`: one entry plus one query → hit and value. Instantiate four times (2 entries × 2 queries), plus priority mux at top.
- No other hierarchy.

## Test plan
- Reset/basic: rst 2 cycles → all outputs 0, in_ready=1. Accept ALU_result=0x11, Dest=3, WB_en=1, Mem_R_en=0 with out_ready=1 → next cycle out_valid=1, wb_value=0x11, Dest=3.
- Load select: Mem_R_en_in=1, Mem_read_value_in=0xDEADBEEF, ALU_result_in=0x100 → wb_value=0xDEADBEEF.
- Back-pressure: out_ready=0, stream A,B,C with in_valid=1:
  - A in H, B in S; in_ready=0 before C is accepted; occupancy=2.
  - release out_ready → A, B, C emitted in order, no loss.
- Flush: with occupancy 2 and in_valid=1, assert flush one cycle → next cycle out_valid=0, occupancy=0, in_ready=1, offered item absent.
- Forwarding priority: H Dest=5 value 0xA, S Dest=5 value 0xB, src_a=5 → fwd_a_hit=1, fwd_a_value=0xB. With WB_en=0 on both, src_b=5 → fwd_b_hit=0, fwd_b_value=0.
- Reset mid-stall: occupancy 2, rst=1 while in_valid=1 → all outputs 0 next cycle; nothing accepted during reset.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared control struct, width limit and write-back value select
package mem_wb_pkg;
  localparam int DW_MAX = 64;
  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
  } ctl_t;
  function automatic logic [DW_MAX-1:0] wb_select(input logic mem_r_en, input logic [DW_MAX-1:0] alu, input logic [DW_MAX-1:0] mem);
    return mem_r_en ? mem : alu;
  endfunction
endpackage

// File: rtl/mem_wb_fwd_match.sv
// mem_wb_fwd_match: one held entry against one query register gives hit and write-back value
module mem_wb_fwd_match
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  ctl_t              ctl,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] mem,
  input  logic [REG_W-1:0]  dest,
  input  logic [REG_W-1:0]  src,
  output logic              hit,
  output logic [DATA_W-1:0] value
);
  assign hit   = ctl.valid & ctl.wb_en & (dest == src);
  assign value = hit ? DATA_W'(wb_select(ctl.mem_r_en, DW_MAX'(alu), DW_MAX'(mem))) : '0;
endmodule

// File: rtl/mem_wb_elastic_reg.sv
// mem_wb_elastic_reg: MEM->WB register with valid/ready, one-entry skid, flush and forwarding lookup
module mem_wb_elastic_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_en_in,
  input  logic              Mem_R_en_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] Mem_read_value_in,
  input  logic [REG_W-1:0]  Dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_en,
  output logic              Mem_R_en,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] Mem_read_value,
  output logic [REG_W-1:0]  Dest,
  output logic [DATA_W-1:0] wb_value,
  input  logic [REG_W-1:0]  src_a,
  input  logic [REG_W-1:0]  src_b,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_a_value,
  output logic [DATA_W-1:0] fwd_b_value,
  output logic [1:0]        occupancy
);
  ctl_t              r_h_ctl, r_s_ctl;
  logic [DATA_W-1:0] r_h_alu, r_h_mem, r_s_alu, r_s_mem;
  logic [REG_W-1:0]  r_h_dest, r_s_dest;
  logic              w_accept, w_pop;
  ctl_t              w_ctl [2];
  logic [DATA_W-1:0] w_alu [2];
  logic [DATA_W-1:0] w_mem [2];
  logic [REG_W-1:0]  w_dest [2];
  logic [REG_W-1:0]  w_src [2];
  logic              w_hit [2][2];
  logic [DATA_W-1:0] w_val [2][2];
  assign in_ready = ~r_s_ctl.valid;
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_pop    = r_h_ctl.valid & out_ready;
  always_ff @(posedge clk)
    if (rst) begin
      r_h_ctl  <= '0;
      r_s_ctl  <= '0;
      r_h_alu  <= '0;
      r_h_mem  <= '0;
      r_s_alu  <= '0;
      r_s_mem  <= '0;
      r_h_dest <= '0;
      r_s_dest <= '0;
    end else if (flush) begin
      r_h_ctl.valid <= 1'b0;
      r_s_ctl.valid <= 1'b0;
    end else begin
      if (!r_h_ctl.valid || w_pop) begin
        if (r_s_ctl.valid) begin
          r_h_ctl  <= r_s_ctl;
          r_h_alu  <= r_s_alu;
          r_h_mem  <= r_s_mem;
          r_h_dest <= r_s_dest;
        end else if (w_accept) begin
          r_h_ctl  <= {1'b1, WB_en_in, Mem_R_en_in};
          r_h_alu  <= ALU_result_in;
          r_h_mem  <= Mem_read_value_in;
          r_h_dest <= Dest_in;
        end else
          r_h_ctl.valid <= 1'b0;
      end
      if (r_s_ctl.valid && w_pop)
        r_s_ctl.valid <= 1'b0;
      else if (r_h_ctl.valid && !w_pop && w_accept) begin
        r_s_ctl  <= {1'b1, WB_en_in, Mem_R_en_in};
        r_s_alu  <= ALU_result_in;
        r_s_mem  <= Mem_read_value_in;
        r_s_dest <= Dest_in;
      end
    end
  assign out_valid      = r_h_ctl.valid;
  assign WB_en          = r_h_ctl.valid & r_h_ctl.wb_en;
  assign Mem_R_en       = r_h_ctl.valid & r_h_ctl.mem_r_en;
  assign ALU_result     = r_h_alu;
  assign Mem_read_value = r_h_mem;
  assign Dest           = r_h_dest;
  assign wb_value       = DATA_W'(wb_select(r_h_ctl.mem_r_en, DW_MAX'(r_h_alu), DW_MAX'(r_h_mem)));
  assign occupancy      = 2'(r_h_ctl.valid) + 2'(r_s_ctl.valid);
  assign w_ctl  = '{r_h_ctl, r_s_ctl};
  assign w_alu  = '{r_h_alu, r_s_alu};
  assign w_mem  = '{r_h_mem, r_s_mem};
  assign w_dest = '{r_h_dest, r_s_dest};
  assign w_src  = '{src_a, src_b};
  for (genvar i = 0; i < 2; i++) begin : g_ent
    for (genvar j = 0; j < 2; j++) begin : g_qry
      mem_wb_fwd_match #(.DATA_W(DATA_W), .REG_W(REG_W)) u_match (
        .ctl  (w_ctl[i]),
        .alu  (w_alu[i]),
        .mem  (w_mem[i]),
        .dest (w_dest[i]),
        .src  (w_src[j]),
        .hit  (w_hit[i][j]),
        .value(w_val[i][j])
      );
    end
  end
  assign fwd_a_hit   = w_hit[1][0] | w_hit[0][0];
  assign fwd_b_hit   = w_hit[1][1] | w_hit[0][1];
  assign fwd_a_value = w_hit[1][0] ? w_val[1][0] : w_val[0][0];
  assign fwd_b_value = w_hit[1][1] ? w_val[1][1] : w_val[0][1];
endmodule
